// File: rtl/vjtag_mem_bridge.sv
// vjtag_mem_bridge: virtual-JTAG IR/DR decoder bridging host scans onto pixel memory.
// Define VJTAG_CHECKSUM_EN to turn IR 00 into a 16-bit written-byte checksum readout.
module vjtag_mem_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              tck,
  input  logic              rst,
  input  logic              tdi,
  output logic              tdo,
  input  logic [1:0]        ir_in,
  output logic [1:0]        ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_uir,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SR_A = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
`ifdef VJTAG_CHECKSUM_EN
  localparam int SR_W = (SR_A > 16) ? SR_A : 16;
`else
  localparam int SR_W = SR_A;
`endif

  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_sh;
  logic [SR_W:0]     sr_ext;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pf;
  logic              re_d;
  logic              wrap;
  logic              last_wr;
  logic              inc;
  logic              is_zero;
  logic              is_addr;
  logic              is_wr;
  logic              is_rd;
  int                len;
`ifdef VJTAG_CHECKSUM_EN
  logic [15:0]       sum;
`else
  logic              byp;
`endif

  always_comb begin
    is_zero = 1'b0;
    is_addr = 1'b0;
    is_wr   = 1'b0;
    is_rd   = 1'b0;
    unique case (1'b1)
      (ir_in == 2'b00): is_zero = 1'b1;
      (ir_in == 2'b01): is_addr = 1'b1;
      (ir_in == 2'b10): is_wr   = 1'b1;
      default:          is_rd   = 1'b1;
    endcase
  end

  always_comb begin
    len = DATA_W;
    if (is_addr) begin
      len = ADDR_W;
    end else if (is_zero) begin
`ifdef VJTAG_CHECKSUM_EN
      len = 16;
`else
      len = 0; // bypass uses its own bit, sr untouched
`endif
    end
  end

  assign sr_ext = {1'b0, sr};

  always_comb begin
    sr_sh = sr;
    for (int i = 0; i < SR_W; i++) begin
      if (i == len - 1) begin
        sr_sh[i] = tdi;
      end else if (i < len - 1) begin
        sr_sh[i] = sr_ext[i+1];
      end
    end
  end

  assign inc      = mem_we | (virtual_state_cdr & is_rd);
  assign mem_addr = addr;
  assign ir_out   = {wrap, last_wr};

`ifdef VJTAG_CHECKSUM_EN
  assign tdo = sr[0];
`else
  assign tdo = is_zero ? byp : sr[0];
`endif

  always_ff @(posedge tck) begin
    if (rst) begin
      sr        <= '0;
      addr      <= '0;
      pf        <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      re_d      <= 1'b0;
      wrap      <= 1'b0;
      last_wr   <= 1'b0;
`ifdef VJTAG_CHECKSUM_EN
      sum       <= '0;
`else
      byp       <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      re_d   <= mem_re;
      if (re_d) pf <= mem_rdata;
      if (inc) begin
        addr <= addr + 1'b1;
        if (&addr) wrap <= 1'b1;
      end
`ifdef VJTAG_CHECKSUM_EN
      if (mem_we) sum <= sum + 16'(mem_wdata);
`endif
      if (virtual_state_sdr) begin
        sr <= sr_sh;
`ifndef VJTAG_CHECKSUM_EN
        if (is_zero) byp <= tdi;
`endif
      end
      if (virtual_state_cdr) begin
        if (is_addr) sr[ADDR_W-1:0] <= addr;
        if (is_rd) begin
          sr[DATA_W-1:0] <= pf;
          mem_re         <= 1'b1;
          last_wr        <= 1'b0;
        end
`ifdef VJTAG_CHECKSUM_EN
        if (is_zero) sr[15:0] <= sum;
`else
        if (is_zero) byp <= 1'b0;
`endif
      end
      if (virtual_state_udr) begin
        if (is_addr) begin
          addr <= sr[ADDR_W-1:0];
          wrap <= 1'b0;
`ifdef VJTAG_CHECKSUM_EN
          sum  <= '0;
`endif
        end
        if (is_wr) begin
          mem_wdata <= sr[DATA_W-1:0];
          mem_we    <= 1'b1;
          last_wr   <= 1'b1;
        end
      end
      // re-entering READ prefetches the byte at the current address
      if (virtual_state_uir && is_rd) mem_re <= 1'b1;
    end
  end

endmodule
